// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Purpose : shared types and constants for the cache request front end:
//           address field widths, access-size and write_enable encodings,
//           the queued request record, the FSM state enum and small helpers.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W = 36;
  localparam int TAG_W  = 24;
  localparam int SET_W  = 6;
  localparam int OFF_W  = 6;
  localparam int DATA_W = 64;
  localparam int LINE_W = 128;

  // Access size: bytes = 1 << size
  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_64 = 2'd3
  } size_e;

  // Operation code presented to the set alongside the enable strobe
  typedef enum logic [2:0] {
    WE_READ  = 3'd0,
    WE_WRITE = 3'd1,
    WE_NOP   = 3'd2
  } we_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // One queued CPU request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    size_e             size;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Keeps the low 8 << size bits of a load result
  function automatic logic [DATA_W-1:0] size_mask(input size_e s);
    case (s)
      SZ_8:    return 64'h0000_0000_0000_00FF;
      SZ_16:   return 64'h0000_0000_0000_FFFF;
      SZ_32:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // True when the access runs past the end of the 64-byte block
  function automatic logic crosses_block(input logic [OFF_W-1:0] off, input size_e s);
    logic [OFF_W:0] end_byte;
    end_byte = {1'b0, off} + ((OFF_W+1)'(1) << s);
    return end_byte > (OFF_W+1)'(64);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// -----------------------------------------------------------------------------
// req_fifo
// Purpose : request queue between the CPU handshake and the issue FSM.
//           Power-of-two depth, pointers wrap naturally, an occupancy count
//           tells full from empty. Head entry is readable combinationally.
// Ports   : clk, rst      clock, async active-high reset
//           i_push/i_data write request and entry (ignored while full)
//           i_pop         remove head (ignored while empty)
//           o_data        head entry
//           o_full/o_empty occupancy flags
// -----------------------------------------------------------------------------
module req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output req_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it was written,
  // and leaving it out keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cache_req_frontend.sv
// -----------------------------------------------------------------------------
// cache_req_frontend
// Purpose : queues CPU load/store requests, decodes the address, issues one
//           operation at a time to a cache set (IDLE -> ISSUE -> WAIT -> RESP)
//           and returns a one-cycle response with data, miss and error flags.
// Ports   : clk, rst                    clock, async active-high reset
//           req_valid/req_ready         CPU request handshake
//           req_addr/write/size/wdata   request fields
//           enable, write_enable        set operation strobe and opcode
//           tag, set_idx, block_offset  decoded address of current operation
//           data_size, write_data       size and store data of current op
//           n_ops                       sequence number of issued operations
//           out_data, data_ready        set read data and its valid
//           read_miss, write_miss       set miss indications
//           rsp_valid/data/miss/err     response to the CPU
// Config  : define ALIGN_CHECK_EN to reject requests whose access runs past
//           the end of the block; they are answered with rsp_err and never
//           reach the set.
// -----------------------------------------------------------------------------
module cache_req_frontend
  import cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [1:0]        enable,
  output logic [2:0]        write_enable,
  output logic [TAG_W-1:0]  tag,
  output logic [SET_W-1:0]  set_idx,
  output logic [OFF_W-1:0]  block_offset,
  output logic [1:0]        data_size,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       n_ops,
  input  logic [LINE_W-1:0] out_data,
  input  logic [1:0]        data_ready,
  input  logic [1:0]        read_miss,
  input  logic [1:0]        write_miss,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_miss,
  output logic              rsp_err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;

  state_e            r_state;
  state_e            w_next_state;
  req_t              r_op;
  logic [31:0]       r_n_ops;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_miss;
  logic              r_rsp_err;

  req_t w_push_req;
  req_t w_head;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_pop;
  logic w_reject;
  logic w_rd_miss;
  logic w_rd_hit;
  logic w_timeout;
  logic w_unused;

  // Only the low doubleword of the set's line is ever returned
  assign w_unused = ^out_data[LINE_W-1:DATA_W];

  // ---------------------------------------------------------------- queue
  assign w_push_req = '{addr: req_addr, write: req_write, size: size_e'(req_size), wdata: req_wdata};
  assign req_ready  = !w_fifo_full;
  assign w_pop      = (r_state == IDLE) && !w_fifo_empty;

  req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (req_valid),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef ALIGN_CHECK_EN
  assign w_reject = crosses_block(w_head.addr[OFF_W-1:0], w_head.size);
`else
  assign w_reject = 1'b0;
`endif

  // ---------------------------------------------------------- set events
  assign w_rd_miss = |read_miss;
  assign w_rd_hit  = |data_ready;
  assign w_timeout = (r_wait_cnt == CNT_W'(RD_TIMEOUT - 1));

  // ------------------------------------------------------ state register
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------------------------------------------------- next state
  // NOTE: the default assignment first means every path assigns
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (w_pop) w_next_state = w_reject ? RESP : ISSUE;
      ISSUE: w_next_state = WAIT;
      WAIT:  if (r_op.write || w_rd_miss || w_rd_hit || w_timeout) w_next_state = RESP;
      RESP:  w_next_state = IDLE;
    endcase
  end

  // ------------------------------------------------------------- outputs
  always_comb begin
    enable       = 2'd0;
    write_enable = WE_NOP;
    rsp_valid    = 1'b0;
    unique case (r_state)
      ISSUE: begin
        enable       = 2'd1;
        write_enable = r_op.write ? WE_WRITE : WE_READ;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ datapath
  // The sequence number advances on the pop that leads to ISSUE, so n_ops
  // already names the operation while its enable pulse is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_n_ops    <= '0;
      r_wait_cnt <= '0;
      r_rsp_data <= '0;
      r_rsp_miss <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_op       <= w_head;
            r_wait_cnt <= '0;
            if (w_reject) begin
              r_rsp_data <= '0;
              r_rsp_miss <= 1'b0;
              r_rsp_err  <= 1'b1;
            end else begin
              r_n_ops <= r_n_ops + 32'd1;
            end
          end
        end
        WAIT: begin
          if (r_op.write) begin
            r_rsp_data <= '0;
            r_rsp_miss <= |write_miss;
            r_rsp_err  <= 1'b0;
          end else if (w_rd_miss) begin
            // Miss wins over a simultaneous data_ready
            r_rsp_data <= '0;
            r_rsp_miss <= 1'b1;
            r_rsp_err  <= 1'b0;
          end else if (w_rd_hit) begin
            r_rsp_data <= out_data[DATA_W-1:0] & size_mask(r_op.size);
            r_rsp_miss <= 1'b0;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_miss <= 1'b1;
            r_rsp_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tag          = r_op.addr[ADDR_W-1:SET_W+OFF_W];
  assign set_idx      = r_op.addr[SET_W+OFF_W-1:OFF_W];
  assign block_offset = r_op.addr[OFF_W-1:0];
  assign data_size    = r_op.size;
  assign write_data   = r_op.wdata;
  assign n_ops        = r_n_ops;
  assign rsp_data     = r_rsp_data;
  assign rsp_miss     = r_rsp_miss;
  assign rsp_err      = r_rsp_err;

endmodule
